// File: rtl/matrix_multiply_pkg.sv
// Shared definitions for the matrix multiply engine: RAM select codes, FSM states,
// accumulator sizing and output saturation.
package matrix_multiply_pkg;

    localparam logic [1:0] SEL_X    = 2'd0;
    localparam logic [1:0] SEL_Y    = 2'd1;
    localparam logic [1:0] SEL_Z    = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    // Width of the intermediate used for saturation; must cover the widest accumulator.
    localparam int SAT_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_MAC,
        ST_STORE,
        ST_DONE
    } mm_state_t;

    function automatic int acc_width(input int data_width, input int max_dim);
        return 2 * data_width + $clog2(max_dim) + 1;
    endfunction

    // Clamp a sign-extended value to the signed data_width range.
    function automatic logic [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                  input int data_width,
                                                  output logic clamped);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (data_width - 1)) - SAT_W'(1);
        lo = ~hi;
        clamped  = 1'b0;
        saturate = value;
        if (value > hi) begin
            saturate = hi;
            clamped  = 1'b1;
        end else if (value < lo) begin
            saturate = lo;
            clamped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/mm_sp_ram.sv
// Single-port RAM with synchronous read (read-before-write) and no reset on contents.
module mm_sp_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/matrix_multiply_engine.sv
// Run-time sized signed fixed-point matrix multiply Z = X*Y (or Z += X*Y) over three
// single-port RAMs shared between the host port and the engine.
module matrix_multiply_engine
    import matrix_multiply_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int MAX_DIM    = 8,
    parameter int DIM_WIDTH  = $clog2(MAX_DIM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  acc_mode,
    input  logic [DIM_WIDTH-1:0]  x_rows,
    input  logic [DIM_WIDTH-1:0]  inner_dim,
    input  logic [DIM_WIDTH-1:0]  y_cols,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_wen,
    input  logic [1:0]            ram_sel,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  sat,
    output logic                  err,
    output mm_state_t             fsm_state
);

    localparam int ACC_W  = acc_width(DATA_WIDTH, MAX_DIM);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = DIM_WIDTH + 1;
    localparam logic [DIM_WIDTH-1:0]  DIM_MAX = DIM_WIDTH'(MAX_DIM);
    localparam logic [ADDR_WIDTH:0]   CELLS   = (ADDR_WIDTH + 1)'(MAX_DIM * MAX_DIM);

    mm_state_t state, state_next;

    logic [DIM_WIDTH-1:0]  m_q, k_q, n_q, row_q, col_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  acc_mode_q;
    logic [ADDR_WIDTH-1:0] x_base_q, x_ptr_q, y_ptr_q, z_ptr_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                  sat_q, err_q, rd_ok_q;
    logic [1:0]            rd_sel_q;

    logic dims_ok, addr_ok, host_write, last_elem, issue, mac_end, clamp;
    logic [ADDR_WIDTH-1:0] x_addr, y_addr, z_addr;
    logic                  x_we, y_we, z_we;
    logic [DATA_WIDTH-1:0] x_rd, y_rd, z_rd, z_wdata, store_val;
    logic signed [PROD_W-1:0] x_ext, y_ext;
    logic signed [ACC_W-1:0]  prod_ext, preload, acc_shift;
    logic signed [SAT_W-1:0]  acc_wide;
    logic [SAT_W-1:0]         sat_wide;
    logic [SAT_W-DATA_WIDTH-1:0] sat_unused;

    assign dims_ok = (x_rows != '0) && (x_rows <= DIM_MAX) &&
                     (inner_dim != '0) && (inner_dim <= DIM_MAX) &&
                     (y_cols != '0) && (y_cols <= DIM_MAX);
    assign addr_ok    = ({1'b0, ram_addr} < CELLS);
    assign busy       = (state inside {ST_PRELOAD, ST_MAC, ST_STORE});
    assign done       = (state == ST_DONE);
    assign sat        = sat_q;
    assign err        = err_q;
    assign fsm_state  = state;
    assign host_write = !busy && ram_wen && addr_ok;

    assign last_elem = (row_q == m_q - DIM_WIDTH'(1)) && (col_q == n_q - DIM_WIDTH'(1));
    assign issue     = (cnt_q < {1'b0, k_q});
    assign mac_end   = (cnt_q == ({1'b0, k_q} + CNT_W'(1)));

    // The engine owns all three RAM ports while busy; otherwise the host does.
    assign x_addr  = busy ? x_ptr_q : ram_addr;
    assign y_addr  = busy ? y_ptr_q : ram_addr;
    assign z_addr  = busy ? z_ptr_q : ram_addr;
    assign x_we    = host_write && (ram_sel == SEL_X);
    assign y_we    = host_write && (ram_sel == SEL_Y);
    assign z_we    = busy ? (state == ST_STORE) : (host_write && (ram_sel == SEL_Z));
    assign z_wdata = busy ? store_val : ram_data_in;

    mm_sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_x_ram (
        .clk(clk), .addr(x_addr), .wen(x_we), .wdata(ram_data_in), .rdata(x_rd));
    mm_sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_y_ram (
        .clk(clk), .addr(y_addr), .wen(y_we), .wdata(ram_data_in), .rdata(y_rd));
    mm_sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_z_ram (
        .clk(clk), .addr(z_addr), .wen(z_we), .wdata(z_wdata), .rdata(z_rd));

    assign x_ext     = {{DATA_WIDTH{x_rd[DATA_WIDTH-1]}}, x_rd};
    assign y_ext     = {{DATA_WIDTH{y_rd[DATA_WIDTH-1]}}, y_rd};
    assign prod_ext  = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign preload   = {{(ACC_W-DATA_WIDTH){z_rd[DATA_WIDTH-1]}}, z_rd} <<< FRAC_BITS;
    assign acc_shift = acc_q >>> FRAC_BITS;
    assign acc_wide  = {{(SAT_W-ACC_W){acc_shift[ACC_W-1]}}, acc_shift};

    always_comb begin
        clamp    = 1'b0;
        sat_wide = saturate(acc_wide, DATA_WIDTH, clamp);
        {sat_unused, store_val} = sat_wide;
    end

    always_comb begin
        ram_data_out = '0;
        if (rd_ok_q) begin
            case (rd_sel_q)
                SEL_X:   ram_data_out = x_rd;
                SEL_Y:   ram_data_out = y_rd;
                SEL_Z:   ram_data_out = z_rd;
                default: ram_data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start is a one-cycle request honoured only in IDLE; done answers it one cycle per run.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!dims_ok)      state_next = ST_DONE;
                    else if (acc_mode) state_next = ST_PRELOAD;
                    else               state_next = ST_MAC;
                end
            end
            ST_PRELOAD: state_next = ST_MAC;
            ST_MAC:     if (mac_end) state_next = ST_STORE;
            ST_STORE: begin
                if (last_elem)       state_next = ST_DONE;
                else if (acc_mode_q) state_next = ST_PRELOAD;
                else                 state_next = ST_MAC;
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q        <= '0;
            k_q        <= '0;
            n_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            acc_mode_q <= 1'b0;
            x_base_q   <= '0;
            x_ptr_q    <= '0;
            y_ptr_q    <= '0;
            z_ptr_q    <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_sel_q   <= SEL_X;
        end else begin
            prod_q   <= x_ext * y_ext;
            rd_ok_q  <= !busy && addr_ok && (ram_sel != SEL_RSVD);
            rd_sel_q <= ram_sel;
            case (state)
                ST_IDLE: begin
                    if (start && dims_ok) begin
                        m_q        <= x_rows;
                        k_q        <= inner_dim;
                        n_q        <= y_cols;
                        acc_mode_q <= acc_mode;
                        row_q      <= '0;
                        col_q      <= '0;
                        cnt_q      <= '0;
                        x_base_q   <= '0;
                        x_ptr_q    <= '0;
                        y_ptr_q    <= '0;
                        z_ptr_q    <= '0;
                        sat_q      <= 1'b0;
                        err_q      <= 1'b0;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_MAC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (issue) begin
                        x_ptr_q <= x_ptr_q + ADDR_WIDTH'(1);
                        y_ptr_q <= y_ptr_q + ADDR_WIDTH'(n_q);
                    end
                    // Z read data (preload) lands on cycle 0; products land from cycle 2 on.
                    if (cnt_q == '0) begin
                        acc_q <= acc_mode_q ? preload : '0;
                    end else if (cnt_q >= CNT_W'(2)) begin
                        acc_q <= acc_q + prod_ext;
                    end
                end
                ST_STORE: begin
                    if (clamp) sat_q <= 1'b1;
                    z_ptr_q <= z_ptr_q + ADDR_WIDTH'(1);
                    cnt_q   <= '0;
                    if (col_q == n_q - DIM_WIDTH'(1)) begin
                        col_q    <= '0;
                        row_q    <= row_q + DIM_WIDTH'(1);
                        x_base_q <= x_base_q + ADDR_WIDTH'(k_q);
                        x_ptr_q  <= x_base_q + ADDR_WIDTH'(k_q);
                        y_ptr_q  <= '0;
                    end else begin
                        col_q   <= col_q + DIM_WIDTH'(1);
                        x_ptr_q <= x_base_q;
                        y_ptr_q <= ADDR_WIDTH'(col_q + DIM_WIDTH'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_multiply_engine.sv
// Bench for matrix_multiply_engine: an integer instance (FRAC_BITS=0) and a Q16 instance
// share all inputs; each scenario checks the instance it targets.
module tb_matrix_multiply_engine;
    import matrix_multiply_pkg::*;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int DMW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           acc_mode = 1'b0;
    logic [DMW-1:0] x_rows = '0, inner_dim = '0, y_cols = '0;
    logic [AW-1:0]  ram_addr = '0;
    logic           ram_wen = 1'b0;
    logic [1:0]     ram_sel = SEL_X;
    logic [DW-1:0]  ram_data_in = '0;

    logic [DW-1:0]  rdo0, rdo16;
    logic           busy0, done0, sat0, err0, busy16, done16, sat16, err16;
    mm_state_t      st0, st16;

    bit             use16 = 1'b0;
    logic [DW-1:0]  rdo_s;
    logic           busy_s, done_s;

    int             checks = 0;
    int             errors = 0;
    logic [DW-1:0]  exp_q[$];

    assign rdo_s  = use16 ? rdo16  : rdo0;
    assign busy_s = use16 ? busy16 : busy0;
    assign done_s = use16 ? done16 : done0;

    always #5 clk = ~clk;

    matrix_multiply_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(0), .MAX_DIM(8)) dut0 (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .x_rows(x_rows),
        .inner_dim(inner_dim), .y_cols(y_cols), .ram_addr(ram_addr), .ram_wen(ram_wen),
        .ram_sel(ram_sel), .ram_data_in(ram_data_in), .ram_data_out(rdo0), .busy(busy0),
        .done(done0), .sat(sat0), .err(err0), .fsm_state(st0));

    matrix_multiply_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(16), .MAX_DIM(8)) dut16 (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .x_rows(x_rows),
        .inner_dim(inner_dim), .y_cols(y_cols), .ram_addr(ram_addr), .ram_wen(ram_wen),
        .ram_sel(ram_sel), .ram_data_in(ram_data_in), .ram_data_out(rdo16), .busy(busy16),
        .done(done16), .sat(sat16), .err(err16), .fsm_state(st16));

    // ---------------- driver tasks ----------------
    task automatic host_write(input logic [1:0] sel, input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        ram_sel = sel; ram_addr = AW'(addr); ram_data_in = data; ram_wen = 1'b1;
        @(negedge clk);
        ram_wen = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] sel, input int addr, output logic [DW-1:0] data);
        @(negedge clk);
        ram_sel = sel; ram_addr = AW'(addr); ram_wen = 1'b0;
        @(negedge clk);
        data = rdo_s;
    endtask

    task automatic start_run(input int m, input int k, input int n, input bit acc);
        @(negedge clk);
        x_rows = DMW'(m); inner_dim = DMW'(k); y_cols = DMW'(n); acc_mode = acc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_n, output int done_n,
                             output bit timed_out);
        busy_n = 0; done_n = 0; timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (busy_s) busy_n++;
            if (done_s) begin
                done_n++;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!timed_out) begin
            repeat (4) begin
                @(negedge clk);
                if (done_s) done_n++;
                if (busy_s) busy_n++;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, sat0, err0, busy16, done16, sat16, err16} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {busy0, done0, sat0, err0, busy16, done16, sat16, err16});
        end
        checks++;
        if (rdo0 !== '0 || rdo16 !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h want 0", rdo0, rdo16);
        end
        checks++;
        if (st0 !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", st0, ST_IDLE);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_2x2();
        for (int i = 0; i < 4; i++) host_write(SEL_X, i, DW'(i + 1));
        for (int i = 0; i < 4; i++) host_write(SEL_Y, i, DW'(i + 5));
    endtask

    task automatic test_basic();
        int bn, dn; bit to; logic [DW-1:0] got, exp;
        use16 = 1'b0;
        load_2x2();
        exp_q.push_back(32'd19); exp_q.push_back(32'd22);
        exp_q.push_back(32'd43); exp_q.push_back(32'd50);
        start_run(2, 2, 2, 1'b0);
        wait_done(200, bn, dn, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
        checks++;
        if (bn !== 20) begin errors++; $display("FAIL basic_busy: got %0d want 20", bn); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL basic_done: got %0d want 1", dn); end
        checks++;
        if (sat0 !== 1'b0 || err0 !== 1'b0) begin
            errors++; $display("FAIL basic_flags: got sat=%b err=%b want 0 0", sat0, err0);
        end
        for (int i = 0; i < 4; i++) begin
            host_read(SEL_Z, i, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_z%0d: got %0d want %0d", i, got, exp); end
        end
    endtask

    task automatic test_accumulate();
        int bn, dn; bit to; logic [DW-1:0] got, exp;
        use16 = 1'b0;
        exp_q.push_back(32'd38); exp_q.push_back(32'd44);
        exp_q.push_back(32'd86); exp_q.push_back(32'd100);
        start_run(2, 2, 2, 1'b1);
        wait_done(200, bn, dn, to);
        checks++;
        if (to) begin errors++; $display("FAIL acc_timeout: got no done want done"); end
        checks++;
        if (bn !== 24) begin errors++; $display("FAIL acc_busy: got %0d want 24", bn); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL acc_done: got %0d want 1", dn); end
        for (int i = 0; i < 4; i++) begin
            host_read(SEL_Z, i, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL acc_z%0d: got %0d want %0d", i, got, exp); end
        end
    endtask

    task automatic test_saturation();
        int bn, dn; bit to; logic [DW-1:0] got, exp;
        use16 = 1'b1;
        host_write(SEL_X, 0, 32'h7FFF0000);
        host_write(SEL_Y, 0, 32'h00020000);
        exp_q.push_back(32'h7FFFFFFF);
        start_run(1, 1, 1, 1'b0);
        wait_done(100, bn, dn, to);
        checks++;
        if (to || bn !== 4) begin errors++; $display("FAIL sat_busy: got %0d want 4", bn); end
        checks++;
        if (sat16 !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b want 1", sat16); end
        host_read(SEL_Z, 0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sat_clamp: got %h want %h", got, exp); end

        host_write(SEL_X, 0, 32'hFFFF8000);
        host_write(SEL_Y, 0, 32'h00010000);
        exp_q.push_back(32'hFFFF8000);
        start_run(1, 1, 1, 1'b0);
        wait_done(100, bn, dn, to);
        checks++;
        if (to || dn !== 1) begin errors++; $display("FAIL neg_done: got %0d want 1", dn); end
        checks++;
        if (sat16 !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b want 0", sat16); end
        host_read(SEL_Z, 0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL neg_half: got %h want %h", got, exp); end
        use16 = 1'b0;
    endtask

    task automatic test_non_square();
        int bn, dn; bit to; logic [DW-1:0] got, exp;
        logic [DW-1:0] yv [6] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
        use16 = 1'b0;
        for (int i = 0; i < 3; i++) host_write(SEL_X, i, DW'(i + 1));
        for (int i = 0; i < 6; i++) host_write(SEL_Y, i, yv[i]);
        exp_q.push_back(32'd4); exp_q.push_back(32'd5);
        start_run(1, 3, 2, 1'b0);
        wait_done(200, bn, dn, to);
        checks++;
        if (to || bn !== 12) begin errors++; $display("FAIL ns_busy: got %0d want 12", bn); end
        for (int i = 0; i < 2; i++) begin
            host_read(SEL_Z, i, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL ns_z%0d: got %0d want %0d", i, got, exp); end
        end

        exp_q.push_back(32'd4); exp_q.push_back(32'd5);
        start_run(1, 0, 2, 1'b0);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 1'b1) begin
            errors++;
            $display("FAIL err_start: got done=%b busy=%b err=%b want 1 0 1", done0, busy0, err0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL err_done_pulse: got %b want 0", done0); end
        for (int i = 0; i < 2; i++) begin
            host_read(SEL_Z, i, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL err_z%0d: got %0d want %0d", i, got, exp); end
        end
    endtask

    task automatic test_ignore_while_busy();
        int bn, dn; bit to; logic [DW-1:0] got, exp;
        use16 = 1'b0;
        load_2x2();
        exp_q.push_back(32'd19); exp_q.push_back(32'd22);
        exp_q.push_back(32'd43); exp_q.push_back(32'd50);
        start_run(2, 2, 2, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; acc_mode = 1'b1; ram_sel = SEL_X; ram_addr = '0;
        ram_data_in = 32'hDEAD; ram_wen = 1'b1;
        @(negedge clk);
        start = 1'b0; acc_mode = 1'b0; ram_wen = 1'b0;
        wait_done(200, bn, dn, to);
        checks++;
        if (to || dn !== 1) begin errors++; $display("FAIL ign_done: got %0d want 1", dn); end
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL ign_err_clear: got %b want 0", err0); end
        for (int i = 0; i < 4; i++) begin
            host_read(SEL_Z, i, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL ign_z%0d: got %0d want %0d", i, got, exp); end
        end
        host_read(SEL_X, 0, got);
        checks++;
        if (got !== 32'd1) begin errors++; $display("FAIL ign_x0: got %0d want 1", got); end
        host_read(SEL_RSVD, 0, got);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL rsvd_read: got %h want 0", got); end
    endtask

    task automatic test_reset_mid_run();
        int dn; logic [DW-1:0] got, exp;
        use16 = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(i + 1));
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(i + 5));
        start_run(2, 2, 2, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || st0 !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_mid: got busy=%b done=%b st=%0d want 0 0 %0d", busy0, done0, st0, ST_IDLE);
        end
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done0) dn++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done0) dn++;
        end
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL rst_no_done: got %0d want 0", dn); end
        for (int i = 0; i < 8; i++) begin
            host_read((i < 4) ? SEL_X : SEL_Y, i % 4, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL rst_keep%0d: got %0d want %0d", i, got, exp); end
        end
    endtask

    task automatic test_random();
        int bn, dn, m, k, n, s; bit to; logic [DW-1:0] got, exp;
        int xa [64];
        int ya [64];
        use16 = 1'b0;
        for (int it = 0; it < 3; it++) begin
            m = int'($urandom_range(4, 1));
            k = int'($urandom_range(4, 1));
            n = int'($urandom_range(4, 1));
            for (int i = 0; i < m * k; i++) begin
                xa[i] = int'($urandom_range(100)) - 50;
                host_write(SEL_X, i, DW'(xa[i]));
            end
            for (int i = 0; i < k * n; i++) begin
                ya[i] = int'($urandom_range(100)) - 50;
                host_write(SEL_Y, i, DW'(ya[i]));
            end
            for (int r = 0; r < m; r++) begin
                for (int c = 0; c < n; c++) begin
                    s = 0;
                    for (int j = 0; j < k; j++) s += xa[r * k + j] * ya[j * n + c];
                    exp_q.push_back(DW'(s));
                end
            end
            start_run(m, k, n, 1'b0);
            wait_done(500, bn, dn, to);
            checks++;
            if (to || bn !== m * n * (k + 3)) begin
                errors++;
                $display("FAIL rnd%0d_busy: got %0d want %0d", it, bn, m * n * (k + 3));
            end
            for (int i = 0; i < m * n; i++) begin
                host_read(SEL_Z, i, got);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL rnd%0d_z%0d: got %0d want %0d", it, i, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_saturation();
        test_non_square();
        test_ignore_while_busy();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
